// File: rtl/channel_3_tick_scheduler_pkg.sv
// Shared definitions for the channel 3 tick scheduler and the sibling channel
// schedulers: state encoding, default tempo and tick-period constants.
package channel_3_tick_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    ARMED  = 2'd3
  } sched_state_e;

  localparam int DEFAULT_TEMPO    = 8;
  localparam int TICK_CLK_DIVIDER = 416667;
  localparam int TICK_DIV_WIDTH   = 19;
  localparam int TEMPO_WIDTH      = 8;

  // True when the tick index sits on the last tick of a note of the given length.
  function automatic logic is_last_tick(input logic [TEMPO_WIDTH-1:0] idx,
                                        input logic [TEMPO_WIDTH-1:0] tempo);
    return idx == (tempo - TEMPO_WIDTH'(1));
  endfunction

endpackage

// File: rtl/channel_3_tick_scheduler_if.sv
// Control/strobe bundle between the control registers and the triangle channel.
// Signal names are given from the scheduler's point of view.
interface channel_3_tick_scheduler_if;
  logic       i_start;
  logic       i_stop;
  logic       i_pause;
  logic [7:0] i_tempo;
  logic       i_tempo_valid;
  logic       i_frame_pulse;
  logic       o_tick_stb;
  logic       o_note_stb;
  logic       o_running;
  logic       o_mute;

  modport master (
    output i_start, i_stop, i_pause, i_tempo, i_tempo_valid, i_frame_pulse,
    input  o_tick_stb, o_note_stb, o_running, o_mute
  );

  modport slave (
    input  i_start, i_stop, i_pause, i_tempo, i_tempo_valid, i_frame_pulse,
    output o_tick_stb, o_note_stb, o_running, o_mute
  );
endinterface

// File: rtl/channel_3_tick_scheduler_tick_divider.sv
// Clock divider shared by the channel schedulers: counts enabled cycles and
// raises o_wrap combinationally on the cycle the count rolls over to zero.
module channel_3_tick_scheduler_tick_divider #(
  parameter int DIVIDE = 4,
  parameter int WIDTH  = 19
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_wrap
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_top;

  assign w_at_top = (r_count == WIDTH'(DIVIDE - 1));
  assign o_wrap   = i_enable & w_at_top & ~i_clear;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_at_top ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/channel_3_tick_scheduler.sv
// Triangle-channel playback controller: start/stop/pause FSM, tick and note strobes,
// run-time tempo. Optional CHANNEL_3_FRAME_SYNC_EN holds RUN until the phase wraps.
module channel_3_tick_scheduler
  import channel_3_tick_scheduler_pkg::*;
#(
  parameter int CLK_DIVIDER            = TICK_CLK_DIVIDER,
  parameter int DIV_WIDTH              = TICK_DIV_WIDTH,
  parameter int DEFAULT_TICKS_PER_NOTE = DEFAULT_TEMPO
) (
  input logic                          i_clk,
  input logic                          i_rst_n,
  channel_3_tick_scheduler_if.slave    bus
);

  localparam logic [TEMPO_WIDTH-1:0] RESET_TEMPO = TEMPO_WIDTH'(DEFAULT_TICKS_PER_NOTE);

`ifdef CHANNEL_3_FRAME_SYNC_EN
  localparam sched_state_e START_STATE = ARMED;
`else
  localparam sched_state_e START_STATE = RUN;
`endif

  sched_state_e           r_state;
  sched_state_e           w_next_state;
  logic [TEMPO_WIDTH-1:0] r_tick_cnt;
  logic [TEMPO_WIDTH-1:0] r_active_tempo;
  logic [TEMPO_WIDTH-1:0] r_pending_tempo;
  logic                   r_pending;
  logic                   r_tick_stb;
  logic                   r_note_stb;
  logic                   r_running;
  logic                   w_div_clear;
  logic                   w_div_enable;
  logic                   w_wrap;
  logic                   w_note_end;
  logic                   w_frame_fall;

`ifdef CHANNEL_3_FRAME_SYNC_EN
  logic r_frame_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_d <= 1'b0;
    end else begin
      r_frame_d <= bus.i_frame_pulse;
    end
  end

  assign w_frame_fall = r_frame_d & ~bus.i_frame_pulse;
`else
  logic w_unused_frame;
  assign w_unused_frame = bus.i_frame_pulse;
  assign w_frame_fall   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Stop beats pause beats start; a pause pulse swallows a coincident start.
  always_comb begin
    w_next_state = r_state;
    if (bus.i_stop) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.i_start && !bus.i_pause) w_next_state = START_STATE;
        RUN:     if (bus.i_pause) w_next_state = PAUSED;
        PAUSED:  if (bus.i_start && !bus.i_pause) w_next_state = START_STATE;
        ARMED: begin
          if (bus.i_pause) begin
            w_next_state = PAUSED;
          end else if (w_frame_fall) begin
            w_next_state = RUN;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Counting stops in the very cycle a pause or stop arrives, so a wrap due then is dropped.
  assign w_div_clear  = (r_state == IDLE) | bus.i_stop;
  assign w_div_enable = (r_state == RUN) & ~bus.i_pause & ~bus.i_stop;
  assign w_note_end   = w_wrap & is_last_tick(r_tick_cnt, r_active_tempo);

  channel_3_tick_scheduler_tick_divider #(
    .DIVIDE (CLK_DIVIDER),
    .WIDTH  (DIV_WIDTH)
  ) u_tick_divider (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_div_clear),
    .i_enable (w_div_enable),
    .o_wrap   (w_wrap)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_div_clear || w_note_end) begin
      r_tick_cnt <= '0;
    end else if (w_wrap) begin
      r_tick_cnt <= r_tick_cnt + TEMPO_WIDTH'(1);
    end
  end

  // A new tempo only takes effect on a note boundary (or at once when idle);
  // a fresh request arriving in the same cycle stays pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active_tempo  <= RESET_TEMPO;
      r_pending_tempo <= RESET_TEMPO;
      r_pending       <= 1'b0;
    end else begin
      if (r_pending && ((r_state == IDLE) || w_note_end)) begin
        r_active_tempo <= r_pending_tempo;
        r_pending      <= 1'b0;
      end
      if (bus.i_tempo_valid && (bus.i_tempo != '0)) begin
        r_pending_tempo <= bus.i_tempo;
        r_pending       <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_stb <= 1'b0;
      r_note_stb <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_tick_stb <= w_wrap;
      r_note_stb <= w_wrap & (r_tick_cnt == '0);
      r_running  <= (w_next_state == RUN);
    end
  end

  assign bus.o_tick_stb = r_tick_stb;
  assign bus.o_note_stb = r_note_stb;
  assign bus.o_running  = r_running;
  assign bus.o_mute     = ~r_running;

endmodule

// File: tb/tb_channel_3_tick_scheduler.sv
// Bench for channel_3_tick_scheduler: directed vector table for the playback corner
// cases, then a randomized run scored against a behavioural model.
module tb_channel_3_tick_scheduler;

  localparam int DIV = 4;
  localparam int TPN = 3;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;

  typedef struct {
    bit       start;
    bit       stop;
    bit       pause;
    bit       frame;
    bit       tempoValid;
    bit [7:0] tempo;
    bit       expTick;
    bit       expNote;
    bit       expRunning;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst_n;

  channel_3_tick_scheduler_if bus();

  channel_3_tick_scheduler #(
    .CLK_DIVIDER            (DIV),
    .DIV_WIDTH              (3),
    .DEFAULT_TICKS_PER_NOTE (TPN)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int vecCount  = 0;
  int missCount = 0;
  vec_t vecTable[$];

  // Directed scenario: cycle numbers count from the first start pulse.
  int startAt[7] = '{0, 21, 35, 79, 82, 90, 93};
  int pauseAt[3] = '{11, 79, 90};
  int stopAt[3]  = '{31, 79, 100};
  int tickAt[17] = '{5, 9, 24, 28, 40, 44, 48, 52, 56, 60, 64, 68, 72, 76, 87, 95, 99};
  int noteAt[9]  = '{5, 28, 40, 52, 60, 68, 76, 87, 99};
  int runFrom[5] = '{1, 22, 36, 83, 94};
  int runTo[5]   = '{11, 31, 79, 90, 100};

  // Reference model state: playback mode, position inside the tick period,
  // position inside the note, and the tempo registers.
  int mMode;
  int mPhase;
  int mTickIdx;
  int mActive;
  int mPending;
  bit mHasPending;

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: tick/note/run/mute got %b want %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    @(negedge i_clk);
    bus.i_start       = v.start;
    bus.i_stop        = v.stop;
    bus.i_pause       = v.pause;
    bus.i_frame_pulse = v.frame;
    bus.i_tempo_valid = v.tempoValid;
    bus.i_tempo       = v.tempo;
    @(posedge i_clk);
    #1;
    checkOutput(name, {bus.o_tick_stb, bus.o_note_stb, bus.o_running, bus.o_mute},
                {v.expTick, v.expNote, v.expRunning, ~v.expRunning});
  endtask

  task automatic doReset(input bit framLevel);
    i_rst_n           = 1'b0;
    bus.i_start       = 1'b0;
    bus.i_stop        = 1'b0;
    bus.i_pause       = 1'b0;
    bus.i_frame_pulse = framLevel;
    bus.i_tempo_valid = 1'b0;
    bus.i_tempo       = 8'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("reset", {bus.o_tick_stb, bus.o_note_stb, bus.o_running, bus.o_mute}, 4'b0001);
  endtask

  task automatic buildDirected();
    vec_t v;
    for (int c = 0; c <= 100; c++) begin
      v = '{default: 0};
      foreach (startAt[k]) if (startAt[k] == c) v.start = 1'b1;
      foreach (pauseAt[k]) if (pauseAt[k] == c) v.pause = 1'b1;
      foreach (stopAt[k])  if (stopAt[k] == c)  v.stop  = 1'b1;
      if (c == 46) begin v.tempoValid = 1'b1; v.tempo = 8'd2; end
      if (c == 65) begin v.tempoValid = 1'b1; v.tempo = 8'd0; end
      foreach (tickAt[k]) if (tickAt[k] == c + 1) v.expTick = 1'b1;
      foreach (noteAt[k]) if (noteAt[k] == c + 1) v.expNote = 1'b1;
      foreach (runFrom[k]) if ((c + 1 >= runFrom[k]) && (c + 1 <= runTo[k])) v.expRunning = 1'b1;
      vecTable.push_back(v);
    end
  endtask

  task automatic buildFrameSync();
    vec_t v;
    for (int c = 0; c <= 22; c++) begin
      v = '{default: 0};
      v.frame      = (c < 7);
      v.start      = (c == 0) || (c == 16);
      v.stop       = (c == 14) || (c == 20);
      v.expTick    = (c + 1 == 12);
      v.expNote    = (c + 1 == 12);
      v.expRunning = (c + 1 >= 8) && (c + 1 <= 14);
      vecTable.push_back(v);
    end
  endtask

  task automatic modelReset();
    mMode       = M_IDLE;
    mPhase      = 0;
    mTickIdx    = 0;
    mActive     = TPN;
    mPending    = TPN;
    mHasPending = 1'b0;
  endtask

  // One clock of playback rules; returns the outputs visible in the following cycle.
  task automatic modelStep(input bit st, input bit sp, input bit pa, input bit tv,
                           input int tp, output bit eTick, output bit eNote, output bit eRun);
    bit counting;
    bit tickNow;
    counting = (mMode == M_RUN) && !sp && !pa;
    tickNow  = counting && (mPhase == DIV - 1);
    eTick    = tickNow;
    eNote    = tickNow && (mTickIdx == 0);
    if (sp || mMode == M_IDLE) begin
      mPhase   = 0;
      mTickIdx = 0;
    end else if (counting) begin
      mPhase = (mPhase + 1) % DIV;
      if (tickNow) begin
        mTickIdx = mTickIdx + 1;
        if (mTickIdx >= mActive) begin
          mTickIdx = 0;
          if (mHasPending) begin
            mActive     = mPending;
            mHasPending = 1'b0;
          end
        end
      end
    end
    if (mMode == M_IDLE && mHasPending) begin
      mActive     = mPending;
      mHasPending = 1'b0;
    end
    if (tv && tp != 0) begin
      mPending    = tp;
      mHasPending = 1'b1;
    end
    if (sp) begin
      mMode = M_IDLE;
    end else if (pa) begin
      if (mMode == M_RUN) mMode = M_PAUSED;
    end else if (st && mMode != M_RUN) begin
      mMode = M_RUN;
    end
    eRun = (mMode == M_RUN);
  endtask

  initial begin
    vec_t v;
`ifdef CHANNEL_3_FRAME_SYNC_EN
    buildFrameSync();
    doReset(1'b1);
    foreach (vecTable[i]) applyStimulus(vecTable[i], $sformatf("sync_c%0d", i));
`else
    buildDirected();
    doReset(1'b0);
    foreach (vecTable[i]) applyStimulus(vecTable[i], $sformatf("dir_c%0d", i));

    doReset(1'b0);
    modelReset();
    for (int n = 0; n < 3000; n++) begin
      v = '{default: 0};
      v.start      = ($urandom_range(0, 9) == 0);
      v.stop       = ($urandom_range(0, 59) == 0);
      v.pause      = ($urandom_range(0, 29) == 0);
      v.frame      = $urandom_range(0, 1) != 0;
      v.tempoValid = ($urandom_range(0, 24) == 0);
      v.tempo      = 8'($urandom_range(0, 4));
      modelStep(v.start, v.stop, v.pause, v.tempoValid, int'(v.tempo),
                v.expTick, v.expNote, v.expRunning);
      applyStimulus(v, $sformatf("rand_%0d", n));
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish, vectors %0d", vecCount);
    $fatal(1, "[TB] timeout");
  end

endmodule
